// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: loader FSM states and datapath widths.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DAT_LO,
    DAT_HI,
    CKS,
    FIN,
    ERR
  } loader_state_t;

  // States in which the loader offers byte_ready to the byte source.
  function automatic logic accepts_byte(loader_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DAT_LO) || (s == DAT_HI) || (s == CKS);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader, bundled as one interface.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  import cpu_pkg::*;

  logic [BYTE_W-1:0]  byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic               im_we;
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_wdata;

  // master: host byte source plus memory write sink; slave: the loader
  modport master (
    output byte_in, byte_valid,
    input  byte_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/imem_loader_byte_pair_assembler.sv
// Latches the low byte of each instruction and emits the registered {high,low} word with a one-cycle write strobe.
module byte_pair_assembler
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               lo_en,
  input  logic               hi_en,
  input  logic [BYTE_W-1:0]  byte_in,
  output logic               we,
  output logic [INSTR_W-1:0] wdata
);

  logic [BYTE_W-1:0] lo_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      lo_reg <= '0;
      we     <= 1'b0;
      wdata  <= '0;
    end else begin
      we <= hi_en;
      if (lo_en) begin
        lo_reg <= byte_in;
      end
      // wdata holds between strobes so the word stays visible after the write
      if (hi_en) begin
        wdata <= {byte_in, lo_reg};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a little-endian length-prefixed byte frame and writes 16-bit words from address 0.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  generate
    if (WORD_W != INSTR_W) begin : g_bad_word_w
      $error("imem_loader: WORD_W must be 16");
    end
  endgenerate

`ifdef IMEM_LOADER_CKSUM_EN
  localparam loader_state_t END_STATE = CKS;
`else
  localparam loader_state_t END_STATE = FIN;
`endif

  loader_state_t     state_reg;
  loader_state_t     state_next;
  logic [BYTE_W-1:0] len_lo_reg;
  logic [CNT_W-1:0]  len_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [15:0]       len_full;
  logic              xfer;
  logic              lo_en;
  logic              hi_en;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [BYTE_W-1:0] cks_reg;
`endif

  assign xfer     = bus.byte_valid && bus.byte_ready;
  assign lo_en    = xfer && (state_reg == DAT_LO);
  assign hi_en    = xfer && (state_reg == DAT_HI);
  assign len_full = {bus.byte_in, len_lo_reg};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start) state_next = LEN_LO;
      LEN_LO: if (xfer) state_next = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (len_full == 16'd0)             state_next = END_STATE;
          else if ({1'b0, len_full} > DEPTH) state_next = ERR;
          else                               state_next = DAT_LO;
        end
      end
      DAT_LO: if (xfer) state_next = DAT_HI;
      DAT_HI: begin
        if (xfer) state_next = (cnt_reg + 1'b1 == len_reg) ? END_STATE : DAT_LO;
      end
`ifdef IMEM_LOADER_CKSUM_EN
      CKS:    if (xfer) state_next = (bus.byte_in == cks_reg) ? FIN : ERR;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      len_lo_reg     <= '0;
      len_reg        <= '0;
      cnt_reg        <= '0;
      bus.byte_ready <= 1'b0;
      bus.im_addr    <= '0;
      cpu_hold       <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      cks_reg        <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      bus.byte_ready <= accepts_byte(state_next);
      done           <= (state_next == FIN);

      if (state_reg == IDLE && start) begin
        cpu_hold <= 1'b1;
        err      <= 1'b0;
        cnt_reg  <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
        cks_reg  <= '0;
`endif
      end else if (state_next == FIN || state_next == ERR) begin
        cpu_hold <= 1'b0;
      end
      if (state_next == ERR) begin
        err <= 1'b1;
      end

      if (xfer && state_reg == LEN_LO) begin
        len_lo_reg <= bus.byte_in;
      end
      if (xfer && state_reg == LEN_HI) begin
        len_reg <= len_full[CNT_W-1:0];
      end
      if (hi_en) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
`ifdef IMEM_LOADER_CKSUM_EN
      if (lo_en || hi_en) begin
        cks_reg <= cks_reg ^ bus.byte_in;
      end
`endif

      // Address advances after each write strobe; a full-depth load wraps back to 0.
      if (state_reg == IDLE && start) begin
        bus.im_addr <= '0;
      end else if (bus.im_we) begin
        bus.im_addr <= bus.im_addr + 1'b1;
      end
    end
  end

  byte_pair_assembler u_asm (
    .clk     (clk),
    .reset   (reset),
    .lo_en   (lo_en),
    .hi_en   (hi_en),
    .byte_in (bus.byte_in),
    .we      (bus.im_we),
    .wdata   (bus.im_wdata)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: frame loads, back-pressure, length limits, reset and start handling.
module tb_imem_loader;
  import cpu_pkg::*;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold;
  logic done;
  logic err;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  int xfer_count = 0;
  int done_count = 0;
  logic [7:0]  wr_addr [512];
  logic [15:0] wr_data [512];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .WORD_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Observe writes, byte transfers and done pulses mid-cycle.
  always @(negedge clk) begin
    if (bus.im_we) begin
      if (wr_count < 512) begin
        wr_addr[wr_count] = bus.im_addr;
        wr_data[wr_count] = bus.im_wdata;
      end
      wr_count++;
    end
    if (bus.byte_valid && bus.byte_ready) xfer_count++;
    if (done) done_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_count = 0;
    xfer_count = 0;
    done_count = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte after `gap` idle cycles and hold it until accepted.
  task automatic send(input logic [7:0] b, input int gap);
    int t;
    bus.byte_valid = 1'b0;
    repeat (gap) tick();
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    t = 0;
    while (!bus.byte_ready && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed byte_ready=0 expected byte_ready=1 for byte %0h", b);
    end
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_we"}, 32'(bus.im_we), 32'd0);
    chk({tag, "_addr"}, 32'(bus.im_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.im_wdata), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic chk_write(input string tag, input logic [7:0] a, input logic [15:0] d);
    chk({tag, "_we"}, 32'(bus.im_we), 32'd1);
    chk({tag, "_addr"}, 32'(bus.im_addr), 32'(a));
    chk({tag, "_wdata"}, 32'(bus.im_wdata), 32'(d));
  endtask

  logic [7:0] frame [8];
  int gaps [8];

  initial begin
    frame = '{8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    gaps  = '{1, 0, 2, 1, 0, 3, 2, 1};
    reset = 1'b1;
    start = 1'b0;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    // A held byte in IDLE is never taken.
    clear_mon();
    bus.byte_in = 8'h55;
    bus.byte_valid = 1'b1;
    tick();
    tick();
    bus.byte_valid = 1'b0;
    chk("idle_no_xfer", 32'(xfer_count), 32'd0);

    // N=3 streaming load
    clear_mon();
    do_start();
    chk("n3_hold", 32'(cpu_hold), 32'd1);
    chk("n3_ready", 32'(bus.byte_ready), 32'd1);
    send(8'h03, 0);
    send(8'h00, 0);
    send(8'h34, 0);
    send(8'h12, 0);
    chk_write("n3_w0", 8'h00, 16'h1234);
    send(8'h78, 0);
    send(8'h56, 0);
    chk_write("n3_w1", 8'h01, 16'h5678);
    send(8'hBC, 0);
    send(8'h9A, 0);
    chk_write("n3_w2", 8'h02, 16'h9ABC);
`ifdef IMEM_LOADER_CKSUM_EN
    chk("n3_done_early", 32'(done), 32'd0);
    send(8'h2E, 0);
`endif
    chk("n3_done", 32'(done), 32'd1);
    chk("n3_hold_fall", 32'(cpu_hold), 32'd0);
    chk("n3_err", 32'(err), 32'd0);
    tick();
    chk("n3_done_pulse", 32'(done), 32'd0);
    chk("n3_addr_after", 32'(bus.im_addr), 32'd3);
    chk("n3_wr_count", 32'(wr_count), 32'd3);

    // Same frame with back-pressure gaps
    clear_mon();
    do_start();
    for (int i = 0; i < 8; i++) send(frame[i], gaps[i]);
`ifdef IMEM_LOADER_CKSUM_EN
    send(8'h2E, 1);
`endif
    tick();
    chk("bp_wr_count", 32'(wr_count), 32'd3);
    chk("bp_a0", 32'(wr_addr[0]), 32'd0);
    chk("bp_d0", 32'(wr_data[0]), 32'h1234);
    chk("bp_a1", 32'(wr_addr[1]), 32'd1);
    chk("bp_d1", 32'(wr_data[1]), 32'h5678);
    chk("bp_a2", 32'(wr_addr[2]), 32'd2);
    chk("bp_d2", 32'(wr_data[2]), 32'h9ABC);
`ifdef IMEM_LOADER_CKSUM_EN
    chk("bp_xfers", 32'(xfer_count), 32'd9);
`else
    chk("bp_xfers", 32'(xfer_count), 32'd8);
`endif
    chk("bp_done_count", 32'(done_count), 32'd1);

    // N=0
    clear_mon();
    do_start();
    send(8'h00, 0);
    send(8'h00, 0);
`ifdef IMEM_LOADER_CKSUM_EN
    send(8'h00, 0);
`endif
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_hold", 32'(cpu_hold), 32'd0);
    tick();
    chk("n0_done_pulse", 32'(done), 32'd0);
    chk("n0_no_write", 32'(wr_count), 32'd0);

    // N=0x0101 exceeds depth
    clear_mon();
    do_start();
    send(8'h01, 0);
    send(8'h01, 0);
    chk("big_err", 32'(err), 32'd1);
    chk("big_hold", 32'(cpu_hold), 32'd0);
    chk("big_done", 32'(done), 32'd0);
    tick();
    chk("big_err_sticky", 32'(err), 32'd1);
    chk("big_no_write", 32'(wr_count), 32'd0);
    do_start();
    chk("big_err_clear", 32'(err), 32'd0);
    chk("big_restart_hold", 32'(cpu_hold), 32'd1);

    // N=256 fills every address and wraps im_addr to 0; word i = {~i, i}
    send(8'h00, 0);
    send(8'h01, 0);
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 0);
      send(~8'(i), 0);
    end
    chk_write("full_last", 8'hFF, 16'h00FF);
`ifdef IMEM_LOADER_CKSUM_EN
    send(8'h00, 0);
`endif
    chk("full_done", 32'(done), 32'd1);
    tick();
    chk("full_wrap_addr", 32'(bus.im_addr), 32'd0);
    chk("full_wr_count", 32'(wr_count), 32'd256);
    chk("full_d0", 32'(wr_data[0]), 32'hFF00);
    chk("full_a128", 32'(wr_addr[128]), 32'd128);
    chk("full_d128", 32'(wr_data[128]), 32'h7F80);

    // Reset after the first word of an N=4 load
    clear_mon();
    do_start();
    send(8'h04, 0);
    send(8'h00, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    chk_write("rst_w0", 8'h00, 16'h2211);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_zero("midrst");
    chk("midrst_wr_count", 32'(wr_count), 32'd1);

    // Fresh N=1 load; a start pulse mid-frame must be ignored
    clear_mon();
    do_start();
    send(8'h01, 0);
    do_start();
    send(8'h00, 0);
    send(8'hEF, 0);
    send(8'hBE, 0);
    chk_write("beef", 8'h00, 16'hBEEF);
`ifdef IMEM_LOADER_CKSUM_EN
    send(8'h51, 0);
`endif
    chk("beef_done", 32'(done), 32'd1);
    tick();
    chk("beef_wr_count", 32'(wr_count), 32'd1);

    // Reset and start together: reset wins
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rststart_ready", 32'(bus.byte_ready), 32'd0);
    chk("rststart_hold", 32'(cpu_hold), 32'd0);
    tick();
    chk("rststart_idle", 32'(bus.byte_ready), 32'd0);

`ifdef IMEM_LOADER_CKSUM_EN
    // Checksum match then mismatch on N=1, data 0F F0
    clear_mon();
    do_start();
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h0F, 0);
    send(8'hF0, 0);
    chk_write("cks_ok_w", 8'h00, 16'hF00F);
    send(8'hFF, 0);
    chk("cks_ok_done", 32'(done), 32'd1);
    chk("cks_ok_err", 32'(err), 32'd0);
    tick();
    clear_mon();
    do_start();
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h0F, 0);
    send(8'hF0, 0);
    chk_write("cks_bad_w", 8'h00, 16'hF00F);
    send(8'h00, 0);
    chk("cks_bad_err", 32'(err), 32'd1);
    tick();
    chk("cks_bad_no_done", 32'(done_count), 32'd0);
    chk("cks_bad_wr_count", 32'(wr_count), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a byte stream (valid/ready), assembles 16-bit instruction words, and writes them to consecutive instruction-memory addresses from 0.
- Holds the CPU (PC register and register-file writes) via cpu_hold while a load is in progress.
- Sits between the host byte source and the instruction memory write port, beside the single-cycle datapath.

Parameters:
- ADDR_W, 8, instruction-memory address width; depth = 2**ADDR_W words.
- WORD_W, 16, instruction width; fixed at 2 bytes, so only 16 is legal.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a load; ignored unless in IDLE
- byte_in  in  8  stream data byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader accepts a byte this cycle
- im_we  out  1  instruction-memory write enable
- im_addr  out  ADDR_W  instruction-memory write address
- im_wdata  out  16  instruction word to write
- cpu_hold  out  1  high while a load is active; CPU must not advance PC
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky error flag, cleared by reset or by an accepted start

Behaviour:
- Reset values: byte_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=0, done=0, err=0; state IDLE; word counter=0.
- Handshake: a byte transfers when byte_valid && byte_ready on a rising edge. byte_ready is high exactly in the LEN_LO, LEN_HI, DAT_LO, DAT_HI (and CKS) states. The source may hold byte_valid indefinitely.
- Frame format, little-endian: LEN_LO, LEN_HI give N words (16-bit). Then N pairs follow, each as low byte then high byte.
- FSM transitions:
  - IDLE --start--> LEN_LO. Same edge: cpu_hold=1, err=0, im_addr=0.
  - LEN_LO --xfer--> LEN_HI.
  - LEN_HI --xfer--> DAT_LO if 0<N<=2**ADDR_W; FIN if N=0; ERR if N>2**ADDR_W.
  - DAT_LO --xfer--> DAT_HI. Low byte is latched.
  - DAT_HI --xfer--> DAT_LO, or FIN after the Nth word.
  - FIN: one cycle; done=1, cpu_hold=0, then IDLE.
  - ERR: err=1, cpu_hold=0, then IDLE. err stays high until reset or the next accepted start.
- Write timing:
  - im_we pulses for one cycle, the cycle after each DAT_HI transfer.
  - In that cycle im_wdata={high,low} and im_addr holds the word's address.
  - im_addr increments the cycle after each im_we.
  - At N=2**ADDR_W the last write goes to the top address; im_addr then wraps to 0 with no extra write.
- The final im_we and the done pulse may coincide; im_we still completes.
- start while not in IDLE is ignored. The bytes of the frame are the only stream input.
- reset mid-load: immediately returns to IDLE with all outputs at reset values. Words already written remain in memory.
- Simultaneous start and reset: reset wins.

Optional Feature:
- Macro IMEM_LOADER_CKSUM_EN.
- Defined: after the last data byte (or after LEN_HI when N=0), state CKS accepts one byte. The byte must equal the XOR of all data bytes, length bytes excluded. Match goes to FIN; mismatch goes to ERR. All im_we writes still occur.
- Undefined: there is no CKS state, and frames end after the data bytes.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum loader_state_t (IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, CKS, FIN, ERR);
  - localparam INSTR_W=16;
  - localparam BYTE_W=8.
- One natural sub-module, byte_pair_assembler: it latches the low byte, combines it with the high byte, and generates the registered im_we/im_wdata. The FSM and counters stay in the top module.

Test Plan:
- Load N=3: bytes 03 00 | 34 12 | 78 56 | BC 9A -> three im_we pulses (addr 0,1,2; data 1234, 5678, 9ABC), then done=1 for one cycle, cpu_hold falls with done, err=0.
- Back-pressure: the same frame with byte_valid toggling 1,0,0,1 at random -> identical writes, each byte accepted exactly once, no write without its high byte.
- N=0: bytes 00 00 -> no im_we, done pulse 1 cycle after the LEN_HI transfer (without CKSUM_EN).
- N=0x0101 with ADDR_W=8 -> err=1 after LEN_HI, no im_we, cpu_hold=0. A following start clears err.
- reset asserted after the 1st word of an N=4 load -> next cycle all outputs 0, state IDLE. A fresh load of N=1 (EF BE) writes BEEF at addr 0.
- CKSUM_EN: N=1, data 0F F0, cks FF -> done. The same frame with cks 00 -> im_we at addr 0 occurs, then err=1 and no done.
